// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared constants for the 4x4 matrix keypad scanner: matrix
//               geometry, idle row drive, debounce FSM state encoding and
//               per-scan result encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // All rows released: nothing is driven low while parked.
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Debounce FSM states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    // Result of one complete four-row scan
    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_SINGLE = 2'd1;
    localparam logic [1:0] RES_MULTI  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/keypad_row_scanner.sv
// ============================================================================
// Module      : keypad_row_scanner
// Description : Column synchronizer, row dwell counter, one-cold row rotation
//               and per-scan hit accumulator. scan_done is a one-cycle strobe
//               during the row-3 sampling cycle; scan_res/scan_code are valid
//               with it and already include the row-3 sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       scan_done,
    output logic [1:0] scan_res,
    output logic [3:0] scan_code
);

    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [1:0]     LAST_ROW   = 2'(NUM_ROWS - 1);

    logic [3:0]    col_meta_q;
    logic [3:0]    col_sync_q;
    logic          active_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    row_idx_q;
    logic [3:0]    row_q;
    logic [1:0]    hits_q;
    logic [3:0]    code_q;
    logic [1:0]    hits_d;
    logic [3:0]    code_d;
    logic          sample;

    // Two-flop synchronizer for the asynchronous, active-low column lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    // Fold the current row's low columns into the running hit count and code
    always_comb begin
        hits_d = hits_q;
        code_d = code_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!col_sync_q[c]) begin
                if (hits_d != 2'd2) begin
                    hits_d = hits_d + 2'd1;
                end
                code_d = {row_idx_q, 2'(c)};
            end
        end
    end

    assign sample    = en && active_q && (dwell_q == DWELL_LAST);
    assign scan_done = sample && (row_idx_q == LAST_ROW);
    assign scan_res  = (hits_d == 2'd0) ? RES_NONE :
                       (hits_d == 2'd1) ? RES_SINGLE : RES_MULTI;
    assign scan_code = code_d;
    assign row_out   = row_q;

    // Row dwell timing, rotation and accumulator; en low parks everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
            row_q     <= ROW_IDLE;
            hits_q    <= 2'd0;
            code_q    <= 4'd0;
        end else if (!en) begin
            active_q  <= 1'b0;
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
            row_q     <= ROW_IDLE;
            hits_q    <= 2'd0;
            code_q    <= 4'd0;
        end else if (!active_q) begin
            active_q  <= 1'b1;
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
            row_q     <= 4'b1110;
        end else if (sample) begin
            dwell_q   <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_q     <= {row_q[2:0], row_q[3]};
            if (row_idx_q == LAST_ROW) begin
                hits_q <= 2'd0;
                code_q <= 4'd0;
            end else begin
                hits_q <= hits_d;
                code_q <= code_d;
            end
        end else begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner with press/release debounce.
//               Emits one key_valid pulse per accepted press (code=row*4+col)
//               and holds key_held while the key stays down.
//               Optional: define KEYPAD_AUTOREPEAT_EN to add auto-repeat
//               pulses after REPEAT_DELAY scans, then every REPEAT_RATE scans.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 16,
    parameter int REPEAT_RATE    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            CW       = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scan: parameter out of range");
    end

    logic          scan_done;
    logic [1:0]    scan_res;
    logic [3:0]    scan_code;

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [3:0]    cand_q,      cand_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q,  key_held_d;
    logic          accept;
    logic          rpt_fire;

    keypad_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scanner (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .col_in    (col_in),
        .row_out   (row_out),
        .scan_done (scan_done),
        .scan_res  (scan_res),
        .scan_code (scan_code)
    );

    // Debounce FSM: advances only on scan-complete strobes, en low forces IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_code_d = key_code_q;
        key_held_d = key_held_q;
        accept     = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            key_held_d = 1'b0;
        end else if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res == RES_SINGLE) begin
                        cand_d  = scan_code;
                        cnt_d   = CW'(1);
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_res == RES_SINGLE && scan_code == cand_q) begin
                        if (cnt_q == DEB_LAST) begin
                            key_code_d = cand_q;
                            key_held_d = 1'b1;
                            accept     = 1'b1;
                            cnt_d      = '0;
                            state_d    = ST_PRESSED;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    // Any activity (same key or another) restarts the release count
                    if (scan_res == RES_NONE) begin
                        if (cnt_q == DEB_LAST) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
        key_valid_d = en && (accept || rpt_fire);
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RMAX             = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW               = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DELAY_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RATE_LAST    = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rpt_cnt_q,   rpt_cnt_d;
    logic          rpt_armed_q, rpt_armed_d;

    // Repeat timer: first fire after REPEAT_DELAY busy scans, then every REPEAT_RATE
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        if (!en || state_q != ST_PRESSED) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (scan_done && scan_res != RES_NONE) begin
            if (!rpt_armed_q && rpt_cnt_q == RPT_DELAY_LAST) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else if (rpt_armed_q && rpt_cnt_q == RPT_RATE_LAST) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    // Repeat timer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// Module      : tb_keypad_scan
// Description : Directed self-checking bench for keypad_scan with
//               SCAN_DIV=4, DEBOUNCE_SCANS=3 (one full scan = 16 cycles).
//               A behavioural keypad drives col_in from row_out and a
//               16-bit pressed-key mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_mask;

    int n_total;
    int n_pass;
    int n_fail;
    int pulse_cnt;
    int dbl_cnt;
    int p0;
    logic prev_valid;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_DELAY   (4),
        .REPEAT_RATE    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its column to its driven-low row
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_out[r] == 1'b0 && key_mask[r*4+c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    // Pulse monitor: counts key_valid pulses and any back-to-back highs
    initial begin
        pulse_cnt  = 0;
        dbl_cnt    = 0;
        prev_valid = 1'b0;
    end
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            if (prev_valid === 1'b1) dbl_cnt++;
        end
        prev_valid = key_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scans(input int n);
        repeat (16 * n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // At scan boundary+1: pulse present with code, gone a cycle later, realign
    task automatic check_pulse(input string tag, input logic [3:0] code);
        check({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
        check({tag, "_code"},  {28'd0, key_code},  {28'd0, code});
        check({tag, "_held"},  {31'd0, key_held},  32'd1);
        tick();
        check({tag, "_valid_off"}, {31'd0, key_valid}, 32'd0);
        repeat (15) tick();
    endtask

    initial begin
        logic exp_v;
        n_total  = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        key_mask = 16'h0000;
        tick();
        tick();

        // Reset state
        check("rst_row",   {28'd0, row_out},   32'hF);
        check("rst_code",  {28'd0, key_code},  32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'h0);
        check("rst_held",  {31'd0, key_held},  32'h0);

        // Row rotation
        rst = 1'b0;
        en  = 1'b1;
        tick();
        check("rot_r0", {28'd0, row_out}, 32'hE);
        repeat (4) tick();
        check("rot_r1", {28'd0, row_out}, 32'hD);
        repeat (4) tick();
        check("rot_r2", {28'd0, row_out}, 32'hB);
        repeat (4) tick();
        check("rot_r3", {28'd0, row_out}, 32'h7);
        repeat (4) tick();
        check("rot_wrap", {28'd0, row_out}, 32'hE);

        // Clean press of key 9 (row 2, col 1)
        key_mask = 16'h0200;
        p0 = pulse_cnt;
        scans(2);
        check("k9_early_valid", {31'd0, key_valid}, 32'd0);
        check("k9_early_held",  {31'd0, key_held},  32'd0);
        scans(1);
        check_pulse("k9", 4'd9);
        scans(3);
        check("k9_held_still", {31'd0, key_held}, 32'd1);
        check("k9_one_pulse", pulse_cnt - p0, 32'd1);
        key_mask = 16'h0000;
        scans(2);
        check("k9_rel_held", {31'd0, key_held}, 32'd1);
        scans(1);
        check("k9_rel_done", {31'd0, key_held}, 32'd0);

        // Bounce on key 5: 2 scans down, 1 up, 3 down
        p0 = pulse_cnt;
        key_mask = 16'h0020;
        scans(2);
        key_mask = 16'h0000;
        scans(1);
        key_mask = 16'h0020;
        scans(2);
        check("k5_no_early", pulse_cnt - p0, 32'd0);
        check("k5_valid_pre", {31'd0, key_valid}, 32'd0);
        scans(1);
        check_pulse("k5", 4'd5);
        key_mask = 16'h0000;
        scans(3);
        check("k5_released", {31'd0, key_held}, 32'd0);
        check("k5_one_pulse", pulse_cnt - p0, 32'd1);

        // Multi-key: 0+15 rejected, then 0 alone accepted, 7 ignored while 0 held
        p0 = pulse_cnt;
        key_mask = 16'h8001;
        scans(3);
        check("multi_no_pulse", pulse_cnt - p0, 32'd0);
        check("multi_held", {31'd0, key_held}, 32'd0);
        check("multi_code", {28'd0, key_code}, 32'd5);
        key_mask = 16'h0001;
        scans(3);
        check_pulse("k0", 4'd0);
        key_mask = 16'h0081;
        scans(3);
        check("roll_held", {31'd0, key_held}, 32'd1);
        check("roll_code", {28'd0, key_code}, 32'd0);
        check("roll_pulses", pulse_cnt - p0, 32'd1);
        key_mask = 16'h0000;
        scans(3);
        check("roll_released", {31'd0, key_held}, 32'd0);

        // Disable during DEBOUNCE on key 6
        p0 = pulse_cnt;
        key_mask = 16'h0040;
        scans(2);
        en = 1'b0;
        tick();
        check("dis_row",   {28'd0, row_out},   32'hF);
        check("dis_code",  {28'd0, key_code},  32'd0);
        check("dis_valid", {31'd0, key_valid}, 32'd0);
        repeat (20) tick();
        check("dis_parked", {28'd0, row_out}, 32'hF);
        check("dis_no_pulse", pulse_cnt - p0, 32'd0);
        en = 1'b1;
        tick();
        check("en_restart_row", {28'd0, row_out}, 32'hE);
        scans(3);
        check_pulse("k6", 4'd6);

        // Asynchronous reset while PRESSED
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_row",   {28'd0, row_out},   32'hF);
        check("mid_rst_code",  {28'd0, key_code},  32'd0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        check("mid_rst_held",  {31'd0, key_held},  32'd0);
        tick();
        key_mask = 16'h0000;
        rst = 1'b0;
        tick();
        check("post_rst_row", {28'd0, row_out}, 32'hE);

        // Key 3 held for 12 scans: repeats only with the optional feature
        p0 = pulse_cnt;
        key_mask = 16'h0008;
        for (int s = 1; s <= 12; s++) begin
            scans(1);
            exp_v = (s == 3) || (AR && (s == 7 || s == 9 || s == 11));
            check($sformatf("rpt_scan%0d", s), {31'd0, key_valid}, {31'd0, exp_v});
        end
        check("rpt_total", pulse_cnt - p0, AR ? 32'd4 : 32'd1);
        check("rpt_code", {28'd0, key_code}, 32'd3);
        key_mask = 16'h0000;
        scans(3);
        check("rpt_released", {31'd0, key_held}, 32'd0);

        check("valid_single_cycle", dbl_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
